tile_128_index_fetch: RTL and testbench

- Pixel-index fetch stage directly upstream of the 128x128 tile palette lookup. Takes the VGA scan position and the tile's screen position, generates the 14-bit address into the tile's 5-bit index ROM, and emits the fetched palette index with a valid flag.
- The index output feeds the palette's 5-bit index input directly. The delayed draw coordinates let the downstream colour mux stay aligned with the fetched index.
- Tile position is shadowed at frame start so that position updates never tear mid-frame.

---
 rtl/tile_128_index_fetch.sv | 67 ++++++
 tb/tb_tile_128_index_fetch.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tile_128_index_fetch.sv
// tile_128_index_fetch: two-stage pixel-index fetch for a 128x128 tile.
// Stage 0 computes the ROM address and tile hit, and stage 1 captures the index.
module tile_128_index_fetch #(
    parameter int         TILE_DIM   = 128,
    parameter int         ADDR_W     = 14,
    parameter logic [9:0] RESET_X    = 10'd256,
    parameter logic [9:0] RESET_Y    = 10'd176,
    parameter logic       TRANSP_EN  = 1'b0,
    parameter logic [4:0] TRANSP_IDX = 5'd0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_start,
    input  logic [9:0]        pos_x_in,
    input  logic [9:0]        pos_y_in,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic              blank_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [4:0]        rom_data,
    output logic [4:0]        pix_index,
    output logic              pix_valid,
    output logic [9:0]        draw_x_d,
    output logic [9:0]        draw_y_d
);
    localparam int DIM_W = ADDR_W / 2;

    logic [9:0]  shadow_x, shadow_y;
    logic [9:0]  draw_x_s0, draw_y_s0;
    logic [10:0] dx, dy;
    logic        hit0, hit1;

    // 11-bit differences go negative left of or above the tile, so there is no wraparound
    always_comb begin
        dx   = {1'b0, draw_x} - {1'b0, shadow_x};
        dy   = {1'b0, draw_y} - {1'b0, shadow_y};
        hit0 = blank_n & ~dx[10] & ~dy[10] & (dx < 11'(TILE_DIM)) & (dy < 11'(TILE_DIM));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            shadow_x  <= RESET_X;
            shadow_y  <= RESET_Y;
            rom_addr  <= '0;
            hit1      <= 1'b0;
            draw_x_s0 <= '0;
            draw_y_s0 <= '0;
            pix_index <= '0;
            pix_valid <= 1'b0;
            draw_x_d  <= '0;
            draw_y_d  <= '0;
        end else begin
            if (frame_start) begin
                shadow_x <= pos_x_in;
                shadow_y <= pos_y_in;
            end
            rom_addr  <= hit0 ? {dy[DIM_W-1:0], dx[DIM_W-1:0]} : '0;
            hit1      <= hit0;
            draw_x_s0 <= draw_x;
            draw_y_s0 <= draw_y;
            pix_index <= rom_data;
            pix_valid <= hit1 & ~(TRANSP_EN & (rom_data == TRANSP_IDX));
            draw_x_d  <= draw_x_s0;
            draw_y_d  <= draw_y_s0;
        end
    end
endmodule

// File: tb/tb_tile_128_index_fetch.sv
// tb_tile_128_index_fetch: directed checks of the tile index fetch stage.
// A second instance is built with transparency enabled (index 0 transparent).
module tb_tile_128_index_fetch;
    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [9:0]  pos_x_in = '0, pos_y_in = '0;
    logic [9:0]  draw_x = '0, draw_y = '0;
    logic        blank_n = 1'b0;
    logic [13:0] rom_addr, tr_rom_addr;
    logic [4:0]  rom_data, tr_rom_data;
    logic [4:0]  pix_index, tr_pix_index;
    logic        pix_valid, tr_pix_valid;
    logic [9:0]  draw_x_d, draw_y_d, tr_draw_x_d, tr_draw_y_d;
    logic [4:0]  rom [0:16383];
    int          tests = 0, fails = 0;
    logic        any_hit;

    always #5 Clk = ~Clk;

    // ROM model: data follows the registered address within the same cycle
    assign rom_data    = rom[rom_addr];
    assign tr_rom_data = rom[tr_rom_addr];

    tile_128_index_fetch u_dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
        .draw_x(draw_x), .draw_y(draw_y), .blank_n(blank_n),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_index(pix_index), .pix_valid(pix_valid),
        .draw_x_d(draw_x_d), .draw_y_d(draw_y_d)
    );

    tile_128_index_fetch #(.TRANSP_EN(1'b1), .TRANSP_IDX(5'd0)) u_tr (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in),
        .draw_x(draw_x), .draw_y(draw_y), .blank_n(blank_n),
        .rom_addr(tr_rom_addr), .rom_data(tr_rom_data),
        .pix_index(tr_pix_index), .pix_valid(tr_pix_valid),
        .draw_x_d(tr_draw_x_d), .draw_y_d(tr_draw_y_d)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_pos(input logic [9:0] x, input logic [9:0] y);
        blank_n     = 1'b0;
        pos_x_in    = x;
        pos_y_in    = y;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Scan one pixel, then a blanked pixel, checking both pipeline stages
    task automatic check_pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                               input logic hit, input logic [13:0] addr);
        draw_x  = x;
        draw_y  = y;
        blank_n = 1'b1;
        tick();
        chk({tag, "_addr"}, 32'(rom_addr), 32'(addr));
        blank_n = 1'b0;
        tick();
        chk({tag, "_valid"}, 32'(pix_valid), 32'(hit));
        chk({tag, "_tr_valid"}, 32'(tr_pix_valid), 32'(hit && rom[addr] != 5'd0));
        if (hit) begin
            chk({tag, "_index"}, 32'(pix_index), 32'(rom[addr]));
            chk({tag, "_dx"}, 32'(draw_x_d), 32'(x));
            chk({tag, "_dy"}, 32'(draw_y_d), 32'(y));
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) rom[i] = 5'((i ^ (i >> 7)) + 9);
        rom[5] = 5'd0;
        rom[6] = 5'd7;
        #3;
        chk("rst_addr", 32'(rom_addr), 32'd0);
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_index", 32'(pix_index), 32'd0);
        chk("rst_dxd", 32'(draw_x_d), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Basic hit at the tile origin and edges
        set_pos(10'd100, 10'd50);
        check_pixel("origin", 10'd100, 10'd50, 1'b1, 14'd0);
        check_pixel("corner", 10'd227, 10'd177, 1'b1, 14'd16383);
        check_pixel("dx128", 10'd228, 10'd177, 1'b0, 14'd0);
        check_pixel("dy128", 10'd100, 10'd178, 1'b0, 14'd0);
        check_pixel("left", 10'd99, 10'd50, 1'b0, 14'd0);
        check_pixel("above", 10'd100, 10'd49, 1'b0, 14'd0);

        // Position shadowing
        pos_x_in = 10'd300;
        check_pixel("noupd_old", 10'd100, 10'd50, 1'b1, 14'd0);
        check_pixel("noupd_new", 10'd300, 10'd50, 1'b0, 14'd0);
        draw_x = 10'd300; draw_y = 10'd50; blank_n = 1'b1;
        pos_y_in = 10'd50; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; blank_n = 1'b0;
        tick();
        chk("fs_same_cycle_valid", 32'(pix_valid), 32'd0);
        check_pixel("after_upd", 10'd300, 10'd50, 1'b1, 14'd0);
        check_pixel("after_upd2", 10'd301, 10'd51, 1'b1, 14'd129);

        // Partially off-screen tile, no wrap
        set_pos(10'd600, 10'd400);
        check_pixel("offscr", 10'd639, 10'd479, 1'b1, 14'd10151);
        check_pixel("offscr_left", 10'd599, 10'd400, 1'b0, 14'd0);
        any_hit = 1'b0;
        for (int y = 400; y < 480; y++) begin
            for (int x = 0; x < 472; x++) begin
                draw_x = 10'(x); draw_y = 10'(y); blank_n = 1'b1;
                tick();
                any_hit |= pix_valid;
            end
        end
        blank_n = 1'b0;
        tick(); any_hit |= pix_valid;
        tick(); any_hit |= pix_valid;
        chk("no_wrap", 32'(any_hit), 32'd0);

        // Shadow parked at 1023 never hits
        set_pos(10'd1023, 10'd1023);
        check_pixel("park_a", 10'd1022, 10'd1022, 1'b0, 14'd0);
        check_pixel("park_b", 10'd0, 10'd0, 1'b0, 14'd0);

        // Transparency (u_tr) versus opaque default (u_dut)
        set_pos(10'd0, 10'd0);
        check_pixel("transp5", 10'd5, 10'd0, 1'b1, 14'd5);
        check_pixel("opaque6", 10'd6, 10'd0, 1'b1, 14'd6);
        chk("tr_index6", 32'(tr_pix_index), 32'd7);
        draw_x = 10'd6; draw_y = 10'd0; blank_n = 1'b0;
        tick(); tick();
        chk("blank_valid", 32'(pix_valid), 32'd0);
        chk("blank_tr_valid", 32'(tr_pix_valid), 32'd0);

        // Asynchronous reset mid-scan
        set_pos(10'd100, 10'd50);
        draw_x = 10'd110; draw_y = 10'd60; blank_n = 1'b1;
        tick(); tick();
        chk("pre_rst_valid", 32'(pix_valid), 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_valid", 32'(pix_valid), 32'd0);
        chk("arst_index", 32'(pix_index), 32'd0);
        chk("arst_addr", 32'(rom_addr), 32'd0);
        chk("arst_dxd", 32'(draw_x_d), 32'd0);
        chk("arst_dyd", 32'(draw_y_d), 32'd0);
        blank_n = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        check_pixel("rst_shadow", 10'd256, 10'd176, 1'b1, 14'd0);
        check_pixel("rst_shadow_end", 10'd383, 10'd303, 1'b1, 14'd16383);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
